// File: rtl/bp_reg_burst_if.sv
// BytePipe byte-stream bus: a downstream byte channel (host to slave) and an
// upstream response channel (slave to host), each with valid/ready.
`timescale 1ns/1ps
interface bp_reg_burst_if;
   logic [7:0] ds_data;
   logic       ds_valid;
   logic       ds_ready;
   logic [7:0] us_data;
   logic       us_valid;
   logic       us_ready;

   modport master (
      output ds_data, ds_valid, us_ready,
      input  ds_ready, us_data, us_valid
   );

   modport slave (
      input  ds_data, ds_valid, us_ready,
      output ds_ready, us_data, us_valid
   );
endinterface

// File: rtl/bp_reg_burst.sv
// BytePipe register-file slave with burst access. A command byte
// {wr, addr[6:0]} and (when LEN_EN) a length byte start a run of count+1
// consecutive data bytes with an auto-incrementing 7-bit address. Every data
// byte yields exactly one response byte: the read data for reads, the
// pre-write register value for writes. Unimplemented addresses read as 0 and
// ignore writes.
`timescale 1ns/1ps
module bp_reg_burst #(
   parameter int N_REG  = 64,
   parameter bit LEN_EN = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_cg,
   bp_reg_burst_if.slave        bp,
   output logic [8*N_REG-1:0]   o_regs
);

   typedef enum logic [1:0] {IDLE, LEN, WDATA, RDATA} state_t;

   state_t             state;
   logic [6:0]         addr;
   logic [7:0]         count;
   logic               wr;
   logic [7:0]         data_q;
   logic               valid_q;
   logic [8*N_REG-1:0] regs;

   logic in_acc;
   logic out_acc;

   // Register read with unimplemented addresses returning zero.
   function automatic logic [7:0] rd(input logic [6:0] a);
      logic [7:0] v;
      v = 8'h00;
      if (int'(a) < N_REG) v = regs[8*int'(a) +: 8];
      return v;
   endfunction

   // Input is refused while a read burst streams, and while an unaccepted
   // response is still pending so no response can ever be overwritten.
   assign bp.ds_ready = i_cg && (state != RDATA) && (!valid_q || bp.us_ready);
   assign in_acc      = bp.ds_valid && bp.ds_ready;
   assign out_acc     = valid_q && bp.us_ready;
   assign bp.us_data  = data_q;
   assign bp.us_valid = valid_q;
   assign o_regs      = regs;

   // Transaction FSM, response register and register file.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         addr    <= '0;
         count   <= '0;
         wr      <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         regs    <= '0;
      end else if (i_cg) begin
         // An accepted response retires unless a branch below reloads it.
         if (out_acc) valid_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_acc) begin
                  wr   <= bp.ds_data[7];
                  addr <= bp.ds_data[6:0];
                  if (LEN_EN) begin
                     state <= LEN;
                  end else begin
                     count <= '0;
                     if (bp.ds_data[7]) begin
                        state <= WDATA;
                     end else begin
                        // No length byte: the read response starts right away.
                        state   <= RDATA;
                        data_q  <= rd(bp.ds_data[6:0]);
                        valid_q <= 1'b1;
                     end
                  end
               end
            end
            LEN: begin
               if (in_acc) begin
                  count <= bp.ds_data;
                  if (wr) begin
                     state <= WDATA;
                  end else begin
                     state   <= RDATA;
                     data_q  <= rd(addr);
                     valid_q <= 1'b1;
                  end
               end
            end
            WDATA: begin
               if (in_acc) begin
                  // Response carries the value being overwritten.
                  data_q  <= rd(addr);
                  valid_q <= 1'b1;
                  if (int'(addr) < N_REG) regs[8*int'(addr) +: 8] <= bp.ds_data;
                  if (count == 8'd0) begin
                     state <= IDLE;
                  end else begin
                     addr  <= addr + 7'd1;
                     count <= count - 8'd1;
                  end
               end
            end
            RDATA: begin
               if (out_acc) begin
                  if (count == 8'd0) begin
                     valid_q <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     // Preload the next byte so a ready host gets one per cycle.
                     addr    <= addr + 7'd1;
                     count   <= count - 8'd1;
                     data_q  <= rd(addr + 7'd1);
                     valid_q <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_reg_burst.sv
// Directed bench for bp_reg_burst: one LEN_EN=1 instance (N_REG=64) and one
// LEN_EN=0 instance (N_REG=8) sharing a host driver. Inputs change 2ns after
// the rising edge; responses are collected on the falling edge.
`timescale 1ns/1ps
module tb_bp_reg_burst;

   logic       clk = 1'b0;
   logic       rst;
   logic       cg;
   logic [7:0] h_data;
   logic       h_valid;
   logic       h_ready;
   logic       sel;

   always #5 clk = ~clk;

   bp_reg_burst_if bus();
   bp_reg_burst_if bus2();

   assign bus.ds_data   = h_data;
   assign bus.ds_valid  = h_valid && !sel;
   assign bus.us_ready  = h_ready;
   assign bus2.ds_data  = h_data;
   assign bus2.ds_valid = h_valid && sel;
   assign bus2.us_ready = h_ready;

   logic [8*64-1:0] regs;
   logic [8*8-1:0]  regs2;

   bp_reg_burst #(.N_REG(64), .LEN_EN(1'b1)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_cg  (cg),
      .bp    (bus.slave),
      .o_regs(regs)
   );

   bp_reg_burst #(.N_REG(8), .LEN_EN(1'b0)) dut2 (
      .i_clk (clk),
      .i_rst (rst),
      .i_cg  (cg),
      .bp    (bus2.slave),
      .o_regs(regs2)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] rq[$];
   time        tq[$];
   logic       hold_pend = 1'b0;
   logic [7:0] hold_d = 8'h00;
   logic       m_v;
   logic       m_r;
   logic [7:0] m_d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response collector; also checks that an unaccepted response holds.
   always @(negedge clk) begin
      m_v = sel ? bus2.us_valid : bus.us_valid;
      m_d = sel ? bus2.us_data  : bus.us_data;
      m_r = h_ready;
      if (hold_pend) chk("hold_stable", {23'd0, m_v, m_d}, {23'd0, 1'b1, hold_d});
      hold_pend = m_v && !m_r;
      hold_d    = m_d;
      if (m_v && m_r) begin
         rq.push_back(m_d);
         tq.push_back($time);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [7:0] b);
      int   n;
      logic rdy;
      h_data  = b;
      h_valid = 1'b1;
      n       = 0;
      rdy     = sel ? bus2.ds_ready : bus.ds_ready;
      while (!rdy && n < 20) begin
         tick();
         n++;
         rdy = sel ? bus2.ds_ready : bus.ds_ready;
      end
      chk("send_ready", 32'(rdy), 32'd1);
      tick();
      h_valid = 1'b0;
   endtask

   task automatic chk_q(input string tag, input int n, input logic [31:0] exp);
      chk({tag, "_count"}, 32'(rq.size()), 32'(n));
      for (int i = 0; i < n && i < rq.size(); i++)
         chk({tag, "_byte"}, 32'(rq[i]), 32'(exp[8*i +: 8]));
      rq.delete();
      tq.delete();
   endtask

   initial begin
      sel     = 1'b0;
      h_valid = 1'b0;
      h_data  = 8'h00;
      h_ready = 1'b1;
      cg      = 1'b1;
      rst     = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_us_valid", 32'(bus.us_valid), 32'd0);
      chk("rst_us_data",  32'(bus.us_data),  32'd0);
      chk("rst_ds_ready", 32'(bus.ds_ready), 32'd1);
      chk("rst_regs",     32'(regs == '0),   32'd1);
      chk("rst_regs2",    32'(regs2 == '0),  32'd1);

      // Single read of an empty register
      send(8'h05); send(8'h00);
      idle(3);
      chk_q("rd5", 1, 32'h00000000);
      chk("rd5_idle_ready", 32'(bus.ds_ready), 32'd1);
      chk("rd5_idle_valid", 32'(bus.us_valid), 32'd0);

      // Write burst to regs 10..12, then read it back at full rate
      send(8'h8A); send(8'h02); send(8'h11); send(8'h22); send(8'h33);
      idle(3);
      chk_q("wr10", 3, 32'h00000000);
      chk("reg10", 32'(regs[87:80]),  32'h11);
      chk("reg11", 32'(regs[95:88]),  32'h22);
      chk("reg12", 32'(regs[103:96]), 32'h33);
      send(8'h0A); send(8'h02);
      idle(4);
      chk("rd10_span", (tq.size() == 3) ? 32'(tq[2] - tq[0]) : 32'hFFFFFFFF, 32'd20);
      chk_q("rd10", 3, 32'h00332211);

      // Top register plus a discarded write past N_REG
      send(8'hBF); send(8'h01); send(8'hAA); send(8'hBB);
      idle(3);
      chk_q("wr63", 2, 32'h00000000);
      chk("reg63", 32'(regs[511:504]), 32'hAA);
      chk("reg0_untouched", 32'(regs[7:0]), 32'h00);
      send(8'h3F); send(8'h01);
      idle(4);
      chk_q("rd63", 2, 32'h000000AA);

      // 7-bit address wrap from 127 to 0
      send(8'h80); send(8'h00); send(8'h5C);
      idle(3);
      chk_q("wr0", 1, 32'h00000000);
      send(8'h7F); send(8'h01);
      idle(4);
      chk_q("wrap", 2, 32'h00005C00);

      // Read burst under toggling upstream backpressure
      send(8'h94); send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
      idle(3);
      chk_q("wr20", 4, 32'h00000000);
      send(8'h14); send(8'h03);
      for (int i = 0; i < 12; i++) begin
         h_ready = (i % 2 == 0);
         if (bus.us_valid) chk("rdata_no_ready", 32'(bus.ds_ready), 32'd0);
         tick();
      end
      h_ready = 1'b1;
      idle(2);
      chk_q("backpressure", 4, 32'hD4C3B2A1);

      // Clock gate off blocks input acceptance
      cg      = 1'b0;
      h_data  = 8'h85;
      h_valid = 1'b1;
      #1;
      chk("cg_ready", 32'(bus.ds_ready), 32'd0);
      tick();
      h_valid = 1'b0;
      cg      = 1'b1;
      tick();

      // Reset in the middle of a write burst
      send(8'h84); send(8'h03); send(8'hE1);
      chk("mid_reg4", 32'(regs[39:32]), 32'hE1);
      chk("mid_reg5", 32'(regs[47:40]), 32'h00);
      h_data  = 8'hE2;
      h_valid = 1'b1;
      rst     = 1'b1;
      tick();
      rst     = 1'b0;
      h_valid = 1'b0;
      chk("rst_mid_regs",  32'(regs == '0),   32'd1);
      chk("rst_mid_valid", 32'(bus.us_valid), 32'd0);
      chk("rst_mid_ready", 32'(bus.ds_ready), 32'd1);
      rq.delete();
      tq.delete();
      send(8'h86); send(8'h00); send(8'h77);
      idle(3);
      chk_q("fresh", 1, 32'h00000000);
      chk("fresh_reg6", 32'(regs[55:48]), 32'h77);
      chk("fresh_reg4", 32'(regs[39:32]), 32'h00);

      // No-length-byte instance: single write then single read
      sel = 1'b1;
      tick();
      send(8'h83); send(8'h7E);
      idle(3);
      send(8'h03);
      idle(3);
      chk_q("nolen", 2, 32'h00007E00);
      chk("nolen_reg3", 32'(regs2[31:24]), 32'h7E);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
